// File: rtl/cla_seq_pkg.sv
// -----------------------------------------------------------------------------
// cla_seq_pkg
// Shared definitions for the multi-precision CLA sequencer:
//   WORD_W     - width of one adder word (16)
//   state_t    - sequencer FSM states (IDLE, RUN, DONE)
//   idx_width  - width of the word index counter for a given word count
// -----------------------------------------------------------------------------
package cla_seq_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // clog2 of the word count, never below one bit so the counter always exists
   function automatic int idx_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/cla_16bit_co.sv
// -----------------------------------------------------------------------------
// cla_16bit_co
// 16-bit carry-lookahead adder (four 4-bit lookahead groups) with the carry-out
// recovered from the operand MSBs and the sum MSB.
// Ports:
//   a, b  in  16  operands
//   cin   in  1   carry in
//   sum   out 16  a + b + cin (low 16 bits)
//   cout  out 1   carry out of bit 15
// -----------------------------------------------------------------------------
module cla_16bit_co
   import cla_seq_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              cin,
   output logic [WORD_W-1:0] sum,
   output logic              cout
);

   logic [WORD_W-1:0] p;   // bit propagate
   logic [WORD_W-2:0] g;   // bit generate (bit 15 never feeds a carry)
   logic [WORD_W-1:0] c;   // carry into each bit
   logic [3:0]        gc;  // carry into each 4-bit group

   assign p     = a ^ b;
   assign g     = a[WORD_W-2:0] & b[WORD_W-2:0];
   assign gc[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_grp
         localparam int B = 4 * gi;
         assign c[B]   = gc[gi];
         assign c[B+1] = g[B] | (p[B] & gc[gi]);
         assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
         assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                       | (p[B+2] & p[B+1] & p[B] & gc[gi]);
         // Group generate/propagate feed the next group's carry; the top group
         // has no successor since cout is recovered from the sum MSB instead.
         if (gi < 3) begin : g_next
            logic grp_g;
            logic grp_p;
            assign grp_g = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                         | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign grp_p = &p[B+3:B];
            assign gc[gi+1] = grp_g | (grp_p & gc[gi]);
         end
      end
   endgenerate

   assign sum  = p ^ c;

   // Carry out from MSBs: generated by both, or propagated when the sum MSB
   // dropped to 0.
   assign cout = (a[WORD_W-1] & b[WORD_W-1])
               | ((a[WORD_W-1] | b[WORD_W-1]) & ~sum[WORD_W-1]);

endmodule

// File: rtl/cla_mp_sequencer.sv
// -----------------------------------------------------------------------------
// cla_mp_sequencer
// Computes a WORDS x 16-bit sum with one shared 16-bit CLA, one word per clock,
// least-significant word first, a carry register linking the words.
// Build option: define CLA_SEQ_SUB_EN to add the in_sub port (a - b).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   in_a, in_b          16*WORDS operands
//   in_cin              carry into word 0
//   in_sub              subtract request (CLA_SEQ_SUB_EN only)
//   out_valid/out_ready result handshake (out_valid high in DONE)
//   out_sum             16*WORDS result, stable until the next accept
//   out_cout            carry out of the most-significant word
//   out_ovf             signed overflow of the full-width result
//   busy                high in RUN or DONE
// -----------------------------------------------------------------------------
module cla_mp_sequencer
   import cla_seq_pkg::*;
#(
   parameter int WORDS = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_W*WORDS-1:0] in_a,
   input  logic [WORD_W*WORDS-1:0] in_b,
   input  logic                  in_cin,
`ifdef CLA_SEQ_SUB_EN
   input  logic                  in_sub,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_W*WORDS-1:0] out_sum,
   output logic                  out_cout,
   output logic                  out_ovf,
   output logic                  busy
);

   localparam int IDX_W = idx_width(WORDS);
   localparam int W     = WORD_W * WORDS;

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  idx_reg;
   logic              carry_reg;
   logic [W-1:0]      a_reg;
   logic [W-1:0]      b_reg;
   logic              cout_reg;
   logic              ovf_reg;
   logic [WORD_W-1:0] sum_words_reg [WORDS];

   logic [W-1:0]      eff_b;
   logic              eff_cin;
   logic [WORD_W-1:0] a_words [WORDS];
   logic [WORD_W-1:0] b_words [WORDS];
   logic [WORD_W-1:0] a_word, b_word, word_sum;
   logic              word_cout;
   logic              accept, last_word;

   // Effective B operand and carry-in captured at accept
`ifdef CLA_SEQ_SUB_EN
   assign eff_b   = in_sub ? ~in_b : in_b;
   assign eff_cin = in_sub | in_cin;
`else
   assign eff_b   = in_b;
   assign eff_cin = in_cin;
`endif

   assign accept    = in_valid & (state_reg == IDLE);
   assign last_word = (idx_reg == IDX_W'(WORDS - 1));

   // Word slicing and the single adder instance fed through the index mux
   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_word
         assign a_words[gi] = a_reg[gi*WORD_W +: WORD_W];
         assign b_words[gi] = b_reg[gi*WORD_W +: WORD_W];
         assign out_sum[gi*WORD_W +: WORD_W] = sum_words_reg[gi];

         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               sum_words_reg[gi] <= '0;
            else if (state_reg == RUN && idx_reg == IDX_W'(gi))
               sum_words_reg[gi] <= word_sum;
         end
      end
   endgenerate

   assign a_word = a_words[idx_reg];
   assign b_word = b_words[idx_reg];

   cla_16bit_co u_cla (
      .a    (a_word),
      .b    (b_word),
      .cin  (carry_reg),
      .sum  (word_sum),
      .cout (word_cout)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // FSM next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept)    state_next = RUN;
         RUN:     if (last_word) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // Operand latch, index counter, carry chain and final flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         if (accept) begin
            a_reg     <= in_a;
            b_reg     <= eff_b;
            carry_reg <= eff_cin;
            idx_reg   <= '0;
         end else if (state_reg == RUN) begin
            carry_reg <= word_cout;
            if (last_word) begin
               // Index holds at WORDS-1 rather than wrapping; reloaded on accept
               cout_reg <= word_cout;
               ovf_reg  <= (a_word[WORD_W-1] == b_word[WORD_W-1]) &
                           (word_sum[WORD_W-1] != a_word[WORD_W-1]);
            end else begin
               idx_reg <= idx_reg + 1'b1;
            end
         end
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);
   assign out_cout  = cout_reg;
   assign out_ovf   = ovf_reg;

endmodule

// File: doc/cla_mp_sequencer.md
# cla_mp_sequencer

Multi-precision adder sequencer that computes a WORDS×16-bit sum using one 16-bit carry-lookahead adder, processing one 16-bit word per clock cycle. Processing runs from the least-significant word to the most-significant word, and a carry register links the words. The block accepts full-width operands through a valid/ready handshake and returns the sum, carry-out and signed-overflow flag through a second valid/ready handshake. It sits between the register/ALU control logic and the shared 16-bit adder datapath.

## Interface
Parameters:
- WORDS, 4, number of 16-bit words per operand; legal range 2..16.

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand request
- in_ready  out  1  high only in IDLE
- in_a  in  16*WORDS  operand A
- in_b  in  16*WORDS  operand B
- in_cin  in  1  carry into word 0
- in_sub  in  1  subtract request; port exists only with CLA_SEQ_SUB_EN
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  16*WORDS  result
- out_cout  out  1  carry out of the most-significant word
- out_ovf  out  1  signed overflow of the full-width result
- busy  out  1  high in RUN or DONE

## Operation
FSM states and transitions:
- IDLE → RUN on in_valid & in_ready.
  - Latch in_a, in_b and the effective carry-in.
  - Set word index idx=0.
- RUN: each cycle, compute word idx as sum[idx] = a[idx] + b_eff[idx] + carry.
  - Register the sum word into out_sum[16*idx +: 16].
  - Update carry ← word carry-out.
  - Increment idx.
  - After the word with idx=WORDS-1, go to DONE.
- DONE: hold out_valid=1.
  - On out_ready, go to IDLE.
  - out_sum, out_cout and out_ovf stay stable until the next accept.

Arithmetic rules:
- Word carry-out = (a15 & b15) | ((a15 | b15) & ~s15). This recovers the carry from the adder's inputs and sum MSB.
- out_cout = carry after the last word.
- out_ovf = (a_msb == b_eff_msb) & (s_msb != a_msb), evaluated on the most-significant word.
- Add: b_eff = in_b, carry-in = in_cin.

Boundary conditions:
- in_valid while not in IDLE is ignored. No queueing.
- out_ready while not in DONE is ignored.
- The idx counter never wraps: its exit condition is idx==WORDS-1.
- rst at any time:
  - State returns to IDLE and the in-flight result is discarded.
  - Reset values: in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, out_ovf=0, idx=0, carry=0.

## Timing
- Accept at edge E.
- Word k is computed on edge E+1+k.
- out_valid is high from the cycle after edge E+WORDS.
- Latency from accept edge to first out_valid cycle: WORDS edges (4 for the default).
- Result handshake completes at edge D.
- in_ready is high from the cycle after D.
- Minimum initiation interval: WORDS+2 cycles.
- in_ready, out_valid and busy are decoded from registered state only. There are no combinational paths from inputs to outputs.

## Configuration
- CLA_SEQ_SUB_EN defined:
  - The in_sub port exists.
  - With in_sub=1 at accept: b_eff = ~in_b, carry-in forced to 1, and in_cin is ignored.
  - out_cout=1 means no borrow.
- CLA_SEQ_SUB_EN undefined:
  - The in_sub port is absent.
  - Add only: b_eff = in_b, carry-in = in_cin.

## Structure
- Package cla_seq_pkg contains:
  - WORD_W=16
  - the FSM state enum (IDLE, RUN, DONE)
  - an index-width constant function, clog2 of WORDS
- Sub-module cla_16bit_co wraps the existing 16-bit CLA.
  - Ports: a, b, cin, sum, cout.
  - It derives cout with the formula in Operation.
  - There is exactly one instance. The sequencer muxes the word slices into it.

## Test plan
All scenarios use WORDS=4.
- Intra-word carry: a=0x0000_0000_0000_FFFF, b=1, cin=0 → sum 0x0000_0000_0001_0000, cout 0, ovf 0, out_valid first high 4 edges after accept.
- Full carry chain: a=0xFFFF_FFFF_FFFF_FFFF, b=1 → sum 0, cout 1, ovf 0.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1 → sum 0x8000_0000_0000_0000, ovf 1, cout 0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while also driving in_valid=1 → out_valid and out_sum stay stable, in_ready stays 0, the extra request is not accepted; out_ready=1 → IDLE next cycle.
- Reset mid-operation: assert rst during the 2nd RUN cycle → out_valid=0 and in_ready=1 immediately; the next operation (a=3, b=4) returns 7.
- Subtract (CLA_SEQ_SUB_EN): a=5, b=7, sub=1 → sum 0xFFFF_FFFF_FFFF_FFFE, cout 0; a=7, b=5 → sum 2, cout 1.
